seven_segment_scanner: RTL and testbench
========================================

Name: seven_segment_scanner

Overview:
- Time-multiplexes NUM_DIGITS BCD digits onto the single shared segment bus and the per-digit anode enables of the Mimas V2 display.
- Each digit slot is preceded by a blanking gap to prevent ghosting.
- New display values are loaded through a pending shadow register and applied only at a frame boundary, so a multi-digit value never tears mid-frame.
- Sits between the stopwatch counter and the display pins.

Parameters:
- NUM_DIGITS, 3, number of multiplexed digits; index 0 is the least significant digit.
- SCAN_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz). Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles per slot with all anodes off, at the start of each slot. Must be at least 1.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; asynchronous, active-low.
- i_enable  input  1  1 = scanning; 0 = display dark.
- i_value  input  4*NUM_DIGITS  BCD digits; digit k is bits [4k+3:4k].
- i_dp  input  NUM_DIGITS  decimal point request per digit; 1 = lit.
- i_lz_suppress  input  1  1 = blank leading zeros.
- i_load  input  1  single-cycle strobe; captures i_value and i_dp into the pending register.
- o_load_ack  output  1  one-cycle pulse when the pending value becomes the displayed value.
- o_frame  output  1  one-cycle pulse at the end of every full frame.
- o_seg  output  8  active-low segments; [7:1] = a,b,c,d,e,f,g; [0] = dp.
- o_an  output  NUM_DIGITS  active-low digit enables.

Behaviour:
- All outputs are registered.
- Reset values:
  - o_an = all 1, o_seg = 8'hFF, o_frame = 0, o_load_ack = 0.
  - Displayed and pending registers = 0; pending flag = 0.
  - FSM = BLANK, digit index = 0, slot counter = 0.
- FSM states: IDLE, BLANK, SHOW.
  - IDLE: o_an all 1, o_seg FF. When i_enable = 1, go to BLANK with index 0 and counter 0.
  - BLANK: o_an all 1, o_seg FF. Lasts exactly BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: only o_an[index] = 0; o_seg = pattern for displayed digit[index]. Lasts SCAN_DIV-BLANK_CYCLES cycles.
  - End of SHOW with index < NUM_DIGITS-1: index increments, go to BLANK.
  - End of SHOW with index = NUM_DIGITS-1: frame boundary. Index wraps to 0, o_frame pulses, go to BLANK.
  - i_enable = 0 in any state: go to IDLE on the next clock, aborting the current slot.
- Timing:
  - Each slot is exactly SCAN_DIV cycles.
  - Each frame is NUM_DIGITS*SCAN_DIV cycles.
  - Only one anode is ever low at a time.
- Segment patterns, active-low, bits [7:1]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - Codes 10-15 = 1111111 (blank).
  - o_seg[0] = ~dp[index].
- Leading-zero suppression (i_lz_suppress = 1):
  - Scanning from digit NUM_DIGITS-1 downward, a digit is blanked while it and every higher digit equal 0 with dp clear.
  - Digit 0 is never blanked.
  - A digit with dp set is never blanked. It still lights dp even if its segments were otherwise suppressible.
  - Suppression is evaluated on the displayed register, not on i_value.
- Load handshake:
  - i_load = 1 on a clock edge copies i_value and i_dp into pending and sets the pending flag.
  - Multiple loads before application: last wins; only one o_load_ack is issued.
  - Application: at the frame boundary, or on the next clock while in IDLE, displayed <= pending, flag clears, and o_load_ack pulses on the same cycle as o_frame (or alone when IDLE).
  - i_load coincident with a frame boundary: the new value is captured and the previous pending value is applied. The new value waits for the next boundary.
- Reset mid-operation:
  - Asynchronous: all outputs go to their reset values immediately.
  - Pending load is discarded; no o_load_ack is issued.

Test Plan:
- NUM_DIGITS=3, SCAN_DIV=10, BLANK_CYCLES=2; release reset, i_enable=1 -> per digit 2 cycles o_an=111 then 8 cycles o_an low; o_an sequence 110,101,011; o_seg=0000001_1; o_frame pulses every 30 cycles.
- i_value=12'h739, i_dp=3'b010, i_load pulse mid-frame -> display unchanged until the boundary; o_load_ack coincides with o_frame; then slots show 9=00011001, 3=00001100 (dp lit), 7=00011111.
- i_lz_suppress=1, value 0x005 -> digits 2 and 1 have o_seg=FF during SHOW, digit 0 shows 5; value 0x000 -> digit 0 shows 0; value 0x000 with dp[1]=1 -> digit 1 o_seg=11111110.
- Two i_load pulses in one frame (0x111 then 0x222) -> a single o_load_ack; display shows 222; 111 never appears.
- i_enable=0 during digit 1 SHOW -> next cycle o_an=111, o_seg=FF; a load while disabled acks on the next clock; re-enable -> 2 blank cycles, then digit 0.
- Assert i_rst_n=0 mid-SHOW with a pending load -> o_an=111 without waiting for a clock edge; after release, display 000 and no o_load_ack.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed BCD scanner for a common-anode 7-segment display with
// per-slot blanking, leading-zero suppression and frame-aligned value updates.
module seven_segment_scanner #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_lz_suppress,
  input  logic                    i_load,
  output logic                    o_load_ack,
  output logic                    o_frame,
  output logic [7:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an
);

  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} state_t;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic                    boundary_s, apply_s, zero_run_s;
  logic [4*NUM_DIGITS-1:0] disp_val_r, disp_val_s, pend_val_r;
  logic [NUM_DIGITS-1:0]   disp_dp_r, disp_dp_s, pend_dp_r, sup_s, an_s, an_r;
  logic                    pend_flag_r, frame_r, ack_r;
  logic [3:0]              digit_s;
  logic [7:0]              seg_s, seg_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Slot sequencing: BLANK then SHOW per digit, disable forces IDLE at once
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r + CNT_W'(1);
    idx_s      = idx_r;
    boundary_s = 1'b0;
    if (!i_enable) begin
      state_s = IDLE;
      cnt_s   = '0;
      idx_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = BLANK;
          cnt_s   = '0;
          idx_s   = '0;
        end
        BLANK: begin
          if (cnt_r == BLANK_LAST) begin
            state_s = SHOW;
            cnt_s   = '0;
          end else begin
            state_s = BLANK;
          end
        end
        SHOW: begin
          if (cnt_r == SHOW_LAST) begin
            state_s = BLANK;
            cnt_s   = '0;
            if (idx_r == IDX_LAST) begin
              idx_s      = '0;
              boundary_s = 1'b1;
            end else begin
              idx_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_s = SHOW;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          idx_s   = '0;
        end
      endcase
    end
  end

  // Pending value moves to the display only at a frame boundary or while idle
  always_comb begin
    apply_s    = pend_flag_r && (boundary_s || (state_r == IDLE));
    disp_val_s = apply_s ? pend_val_r : disp_val_r;
    disp_dp_s  = apply_s ? pend_dp_r  : disp_dp_r;
  end

  // Segments of a digit are suppressed while it and all higher digits are
  // zero and no higher digit carries a decimal point; its own dp still shows.
  always_comb begin
    zero_run_s = i_lz_suppress;
    sup_s      = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run_s = zero_run_s & (disp_val_s[4*k +: 4] == 4'd0);
      sup_s[k]   = zero_run_s;
      zero_run_s = zero_run_s & ~disp_dp_s[k];
    end
  end

  assign digit_s = disp_val_s[{idx_s, 2'b00} +: 4];

  // Output image for the upcoming cycle, registered below
  always_comb begin
    seg_s = 8'hFF;
    an_s  = '1;
    if (state_s == SHOW) begin
      an_s[idx_s] = 1'b0;
      seg_s       = {(sup_s[idx_s] ? 7'h7F : seg_decode(digit_s)), ~disp_dp_s[idx_s]};
    end else begin
      seg_s = 8'hFF;
      an_s  = '1;
    end
  end

  // All state and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= BLANK;
      cnt_r       <= '0;
      idx_r       <= '0;
      disp_val_r  <= '0;
      disp_dp_r   <= '0;
      pend_val_r  <= '0;
      pend_dp_r   <= '0;
      pend_flag_r <= 1'b0;
      seg_r       <= 8'hFF;
      an_r        <= '1;
      frame_r     <= 1'b0;
      ack_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      idx_r      <= idx_s;
      disp_val_r <= disp_val_s;
      disp_dp_r  <= disp_dp_s;
      if (i_load) begin
        pend_val_r  <= i_value;
        pend_dp_r   <= i_dp;
        pend_flag_r <= 1'b1;
      end else if (apply_s) begin
        pend_flag_r <= 1'b0;
      end
      seg_r   <= seg_s;
      an_r    <= an_s;
      frame_r <= boundary_s;
      ack_r   <= apply_s;
    end
  end

  assign o_seg      = seg_r;
  assign o_an       = an_r;
  assign o_frame    = frame_r;
  assign o_load_ack = ack_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (3 digits, 10-cycle slots, 2 blank):
// every cycle is compared against a frame-position model with hand-coded segments.
module tb_seven_segment_scanner;

  logic        i_clk, i_rst_n, i_enable, i_lz_suppress, i_load;
  logic [11:0] i_value;
  logic [2:0]  i_dp, o_an;
  logic        o_load_ack, o_frame;
  logic [7:0]  o_seg;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [11:0] value;
    logic [2:0]  dp;
    logic        lz;
    logic [7:0]  s0, s1, s2;
  } vec_t;

  vec_t vecs[8];

  seven_segment_scanner #(.NUM_DIGITS(3), .SCAN_DIV(10), .BLANK_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_value(i_value),
    .i_dp(i_dp), .i_lz_suppress(i_lz_suppress), .i_load(i_load),
    .o_load_ack(o_load_ack), .o_frame(o_frame), .o_seg(o_seg), .o_an(o_an)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {o_an, o_seg} at frame position p (0..29) for given per-digit segment codes
  function automatic logic [10:0] slot_exp(input int p, input logic [7:0] s0, s1, s2);
    int slot;
    int w;
    logic [7:0] s;
    slot = p / 10;
    w    = p % 10;
    if (w < 2) return {3'b111, 8'hFF};
    case (slot)
      0:       s = s0;
      1:       s = s1;
      default: s = s2;
    endcase
    return {~(3'b001 << slot), s};
  endfunction

  task automatic check(input string name, input int p, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s p=%0d {ack,frame,an,seg} got %b required %b", name, p, act, exp);
    end
  endtask

  // Checks one 30-cycle frame starting at the current negedge; optional loads at la/lb
  task automatic run_frame(input string name, input logic [7:0] s0, s1, s2,
                           input logic frame0, input logic ack0,
                           input int la, input logic [11:0] va, input logic [2:0] da,
                           input int lb, input logic [11:0] vb, input logic [2:0] db,
                           input logic lz_next);
    for (int p = 0; p < 30; p++) begin
      check(name, p, {o_load_ack, o_frame, o_an, o_seg},
            {((p == 0) ? ack0 : 1'b0), ((p == 0) ? frame0 : 1'b0), slot_exp(p, s0, s1, s2)});
      i_load = 1'b0;
      if (p == la) begin i_load = 1'b1; i_value = va; i_dp = da; end
      if (p == lb) begin i_load = 1'b1; i_value = vb; i_dp = db; end
      if (p == 29) i_lz_suppress = lz_next;
      @(negedge i_clk);
    end
    i_load = 1'b0;
  endtask

  initial begin
    logic [7:0] p0, p1, p2;
    logic       ack_exp;
    logic       first;

    vecs[0] = '{12'h739, 3'b010, 1'b0, 8'h19, 8'h0C, 8'h1F};
    vecs[1] = '{12'h005, 3'b000, 1'b1, 8'h49, 8'hFF, 8'hFF};
    vecs[2] = '{12'h000, 3'b000, 1'b1, 8'h03, 8'hFF, 8'hFF};
    vecs[3] = '{12'h000, 3'b010, 1'b1, 8'h03, 8'hFE, 8'hFF};
    vecs[4] = '{12'hA86, 3'b001, 1'b0, 8'h40, 8'h01, 8'hFF};
    vecs[5] = '{12'h024, 3'b000, 1'b1, 8'h99, 8'h25, 8'hFF};
    vecs[6] = '{12'h100, 3'b000, 1'b1, 8'h03, 8'h03, 8'h9F};
    vecs[7] = '{12'h000, 3'b100, 1'b1, 8'h03, 8'h03, 8'hFE};

    i_rst_n = 1'b0; i_enable = 1'b1; i_lz_suppress = 1'b0; i_load = 1'b0;
    i_value = 12'h000; i_dp = 3'b000;
    repeat (3) @(negedge i_clk);
    check("reset_state", 0, {o_load_ack, o_frame, o_an, o_seg}, {1'b0, 1'b0, 3'b111, 8'hFF});
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);

    // Table: each value loaded mid-frame, must appear only after the boundary
    p0 = 8'h03; p1 = 8'h03; p2 = 8'h03; first = 1'b1; ack_exp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d_prev", i), p0, p1, p2, ~first, ack_exp,
                12, vecs[i].value, vecs[i].dp, -1, 12'h000, 3'b000, vecs[i].lz);
      p0 = vecs[i].s0; p1 = vecs[i].s1; p2 = vecs[i].s2;
      first = 1'b0; ack_exp = 1'b1;
    end
    run_frame("vec7_show", p0, p1, p2, 1'b1, 1'b1, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b1);

    // Two loads in one frame: last wins, single ack
    run_frame("dbl_load", p0, p1, p2, 1'b1, 1'b0, 5, 12'h111, 3'b000, 20, 12'h222, 3'b000, 1'b0);
    // Load coincident with the boundary waits one more frame
    run_frame("dbl_show", 8'h25, 8'h25, 8'h25, 1'b1, 1'b1, 10, 12'h384, 3'b000, 29, 12'h516, 3'b100, 1'b0);
    run_frame("bnd_a", 8'h99, 8'h01, 8'h0D, 1'b1, 1'b1, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b0);
    run_frame("bnd_b", 8'h41, 8'h9F, 8'h48, 1'b1, 1'b1, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b0);

    // Disable during digit 1 SHOW, load while idle, then re-enable
    for (int p = 0; p <= 14; p++) begin
      check("pre_disable", p, {o_load_ack, o_frame, o_an, o_seg},
            {1'b0, (p == 0), slot_exp(p, 8'h41, 8'h9F, 8'h48)});
      if (p == 14) i_enable = 1'b0;
      @(negedge i_clk);
    end
    check("disabled_dark", 0, {o_load_ack, o_frame, o_an, o_seg}, {1'b0, 1'b0, 3'b111, 8'hFF});
    i_load = 1'b1; i_value = 12'h050; i_dp = 3'b000;
    @(negedge i_clk);
    i_load = 1'b0;
    check("idle_capture", 1, {o_load_ack, o_frame, o_an, o_seg}, {1'b0, 1'b0, 3'b111, 8'hFF});
    @(negedge i_clk);
    check("idle_ack", 2, {o_load_ack, o_frame, o_an, o_seg}, {1'b1, 1'b0, 3'b111, 8'hFF});
    @(negedge i_clk);
    check("idle_ack_end", 3, {o_load_ack, o_frame, o_an, o_seg}, {1'b0, 1'b0, 3'b111, 8'hFF});
    i_enable = 1'b1;
    @(negedge i_clk);
    run_frame("reenable", 8'h03, 8'h49, 8'h03, 1'b0, 1'b0, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b0);

    // Asynchronous reset mid-SHOW with a pending load
    for (int p = 0; p <= 15; p++) begin
      check("pre_reset", p, {o_load_ack, o_frame, o_an, o_seg},
            {1'b0, (p == 0), slot_exp(p, 8'h03, 8'h49, 8'h03)});
      i_load = (p == 12);
      if (p == 12) begin i_value = 12'h999; i_dp = 3'b111; end
      if (p < 15) @(negedge i_clk);
    end
    i_load = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("reset_async", 15, {o_load_ack, o_frame, o_an, o_seg}, {1'b0, 1'b0, 3'b111, 8'hFF});
    @(posedge i_clk); @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    run_frame("post_reset", 8'h03, 8'h03, 8'h03, 1'b0, 1'b0, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b0);
    run_frame("post_reset2", 8'h03, 8'h03, 8'h03, 1'b1, 1'b0, -1, 12'h000, 3'b000, -1, 12'h000, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
